// File: rtl/acc_cpu_pipe3.sv
// 3-stage (IF/ID/EX) pipelined accumulator CPU with flags, branches, halt and store-to-load forwarding.
// Optional performance counters are enabled by defining ACC_CPU_PERF_CNT_EN.
module acc_cpu_pipe3 #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned OPERAND_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [3+OPERAND_W:0]   imem_data,
    output logic [OPERAND_W-1:0]   dmem_raddr,
    input  logic [DATA_W-1:0]      dmem_rdata,
    output logic                   dmem_we,
    output logic [OPERAND_W-1:0]   dmem_waddr,
    output logic [DATA_W-1:0]      dmem_wdata,
    output logic [DATA_W-1:0]      acc_out,
    output logic                   zero_flag,
    output logic                   carry_flag,
    output logic                   halted
`ifdef ACC_CPU_PERF_CNT_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_retired
`endif
);

    localparam int unsigned IW = 4 + OPERAND_W;

    typedef enum logic [3:0] {
        OpNop, OpLda, OpSta, OpAdd, OpSub, OpAnd, OpOr, OpXor,
        OpLdi, OpAddi, OpNot, OpShl, OpJmp, OpJz, OpJc, OpHlt
    } op_e;

    logic [ADDR_W-1:0]    r_pc;
    logic [IW-1:0]        r_ifid;
    logic [IW-1:0]        r_ex_instr;
    logic [DATA_W-1:0]    r_ex_val;
    logic [DATA_W-1:0]    r_acc;
    logic                 r_z;
    logic                 r_c;
    logic                 r_halted;

    op_e                  w_ex_op;
    logic [OPERAND_W-1:0] w_ex_opnd;
    logic [OPERAND_W-1:0] w_id_opnd;
    logic [DATA_W-1:0]    w_id_val;
    logic [DATA_W-1:0]    w_imm;
    logic [ADDR_W-1:0]    w_target;
    logic [DATA_W:0]      w_sum;
    logic [DATA_W-1:0]    w_acc_d;
    logic                 w_c_d;
    logic                 w_acc_we;
    logic                 w_taken;

    assign w_ex_op   = op_e'(r_ex_instr[IW-1 -: 4]);
    assign w_ex_opnd = r_ex_instr[OPERAND_W-1:0];
    assign w_id_opnd = r_ifid[OPERAND_W-1:0];
    assign w_imm     = DATA_W'(w_ex_opnd);
    assign w_target  = ADDR_W'(w_ex_opnd);

    // A store sitting in EX has not reached memory yet, so a same-address load in ID takes acc.
    assign w_id_val = (w_ex_op == OpSta && w_ex_opnd == w_id_opnd) ? r_acc : dmem_rdata;

    assign imem_addr  = r_pc;
    assign dmem_raddr = w_id_opnd;
    assign dmem_we    = !r_halted && (w_ex_op == OpSta);
    assign dmem_waddr = w_ex_opnd;
    assign dmem_wdata = r_acc;
    assign acc_out    = r_acc;
    assign zero_flag  = r_z;
    assign carry_flag = r_c;
    assign halted     = r_halted;

    always_comb begin
        w_acc_d  = r_acc;
        w_c_d    = r_c;
        w_acc_we = 1'b0;
        w_sum    = '0;
        case (w_ex_op)
            OpLda: begin
                w_acc_d  = r_ex_val;
                w_acc_we = 1'b1;
            end
            OpAdd: begin
                w_sum    = {1'b0, r_acc} + {1'b0, r_ex_val};
                w_acc_d  = w_sum[DATA_W-1:0];
                w_c_d    = w_sum[DATA_W];
                w_acc_we = 1'b1;
            end
            OpSub: begin
                // Bit DATA_W of the extended difference is the borrow.
                w_sum    = {1'b0, r_acc} - {1'b0, r_ex_val};
                w_acc_d  = w_sum[DATA_W-1:0];
                w_c_d    = w_sum[DATA_W];
                w_acc_we = 1'b1;
            end
            OpAnd: begin
                w_acc_d  = r_acc & r_ex_val;
                w_acc_we = 1'b1;
            end
            OpOr: begin
                w_acc_d  = r_acc | r_ex_val;
                w_acc_we = 1'b1;
            end
            OpXor: begin
                w_acc_d  = r_acc ^ r_ex_val;
                w_acc_we = 1'b1;
            end
            OpLdi: begin
                w_acc_d  = w_imm;
                w_acc_we = 1'b1;
            end
            OpAddi: begin
                w_sum    = {1'b0, r_acc} + {1'b0, w_imm};
                w_acc_d  = w_sum[DATA_W-1:0];
                w_c_d    = w_sum[DATA_W];
                w_acc_we = 1'b1;
            end
            OpNot: begin
                w_acc_d  = ~r_acc;
                w_acc_we = 1'b1;
            end
            OpShl: begin
                w_acc_d  = r_acc << 1;
                w_c_d    = r_acc[DATA_W-1];
                w_acc_we = 1'b1;
            end
            default: begin
                w_acc_we = 1'b0;
            end
        endcase
    end

    assign w_taken = (w_ex_op == OpJmp) || (w_ex_op == OpJz && r_z) || (w_ex_op == OpJc && r_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= '0;
            r_ifid     <= '0;
            r_ex_instr <= '0;
            r_ex_val   <= '0;
            r_acc      <= '0;
            r_z        <= 1'b0;
            r_c        <= 1'b0;
            r_halted   <= 1'b0;
        end else if (!r_halted) begin
            if (w_ex_op == OpHlt) begin
                r_halted <= 1'b1;
            end else begin
                if (w_acc_we) begin
                    r_acc <= w_acc_d;
                    r_z   <= (w_acc_d == '0);
                    r_c   <= w_c_d;
                end
                if (w_taken) begin
                    r_pc       <= w_target;
                    r_ifid     <= '0;
                    r_ex_instr <= '0;
                    r_ex_val   <= '0;
                end else begin
                    r_pc       <= r_pc + ADDR_W'(1);
                    r_ifid     <= imem_data;
                    r_ex_instr <= r_ifid;
                    r_ex_val   <= w_id_val;
                end
            end
        end
    end

`ifdef ACC_CPU_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_retired;

    // Flush bubbles are all-zero, so they are excluded together with real NOPs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_cycles  <= '0;
            r_perf_retired <= '0;
        end else if (!r_halted) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
            if (w_ex_op != OpNop) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_retired = r_perf_retired;
`endif

endmodule

// File: tb/tb_acc_cpu_pipe3.sv
// Scoreboard bench for acc_cpu_pipe3: directed programs push expected snapshots/stores,
// a negedge monitor pops and compares them.
module tb_acc_cpu_pipe3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [3:0] dmem_raddr;
    logic [7:0] dmem_rdata;
    logic       dmem_we;
    logic [3:0] dmem_waddr;
    logic [7:0] dmem_wdata;
    logic [7:0] acc_out;
    logic       zero_flag;
    logic       carry_flag;
    logic       halted;

    always #5 clk = ~clk;

    acc_cpu_pipe3 #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .OPERAND_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .dmem_raddr(dmem_raddr),
        .dmem_rdata(dmem_rdata),
        .dmem_we   (dmem_we),
        .dmem_waddr(dmem_waddr),
        .dmem_wdata(dmem_wdata),
        .acc_out   (acc_out),
        .zero_flag (zero_flag),
        .carry_flag(carry_flag),
        .halted    (halted)
    );

    logic [7:0] imem[256];
    logic [7:0] dmem[16];
    logic [7:0] dmem_init[16];

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_raddr];

    always @(posedge clk) begin
        if (!reset) dmem <= dmem_init;
        else if (dmem_we) dmem[dmem_waddr] <= dmem_wdata;
    end

    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    typedef struct {
        int         tid;
        int         cyc;
        string      tag;
        logic [7:0] pc;
        logic [7:0] acc;
        logic       z;
        logic       c;
        logic       h;
    } exp_t;

    typedef struct {
        int         tid;
        int         cyc;
        string      tag;
        logic [3:0] a;
        logic [7:0] d;
    } st_t;

    exp_t exp_q[$];
    st_t  st_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cur_tid = 0;
    bit   armed = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        st_t  s;
        if (armed) begin
            if (!reset) begin
                while (exp_q.size() > 0 && exp_q[0].tid != cur_tid) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL %s: never sampled, required pc=%h acc=%h at cyc %0d",
                             e.tag, e.pc, e.acc, e.cyc);
                end
                while (st_q.size() > 0 && st_q[0].tid != cur_tid) begin
                    s = st_q.pop_front();
                    n_cmp++;
                    n_fail++;
                    $display("FAIL %s: store never seen, required addr=%h data=%h at cyc %0d",
                             s.tag, s.a, s.d, s.cyc);
                end
                n_cmp++;
                if ({imem_addr, acc_out, zero_flag, carry_flag, halted, dmem_we} !== 20'h0) begin
                    n_fail++;
                    $display("FAIL reset_state: pc=%h acc=%h z=%b c=%b h=%b we=%b, required all 0",
                             imem_addr, acc_out, zero_flag, carry_flag, halted, dmem_we);
                end
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (e.cyc != cyc ||
                        {imem_addr, acc_out, zero_flag, carry_flag, halted} !==
                        {e.pc, e.acc, e.z, e.c, e.h}) begin
                        n_fail++;
                        $display("FAIL %s cyc=%0d: got pc=%h acc=%h z=%b c=%b h=%b, required cyc=%0d pc=%h acc=%h z=%b c=%b h=%b",
                                 e.tag, cyc, imem_addr, acc_out, zero_flag, carry_flag, halted,
                                 e.cyc, e.pc, e.acc, e.z, e.c, e.h);
                    end
                end
                if (dmem_we) begin
                    n_cmp++;
                    if (st_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_store cyc=%0d: got addr=%h data=%h, required no store",
                                 cyc, dmem_waddr, dmem_wdata);
                    end else begin
                        s = st_q.pop_front();
                        if (s.cyc != cyc || dmem_waddr !== s.a || dmem_wdata !== s.d) begin
                            n_fail++;
                            $display("FAIL %s cyc=%0d: got addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                                     s.tag, cyc, dmem_waddr, dmem_wdata, s.cyc, s.a, s.d);
                        end
                    end
                end
            end
        end
    end

    task automatic exp_s(input int c, input string t, input logic [7:0] pc, input logic [7:0] a,
                         input logic z, input logic cf, input logic h);
        exp_t e;
        e = '{cur_tid, c, t, pc, a, z, cf, h};
        exp_q.push_back(e);
    endtask

    task automatic exp_w(input int c, input string t, input logic [3:0] a, input logic [7:0] d);
        st_t s;
        s = '{cur_tid, c, t, a, d};
        st_q.push_back(s);
    endtask

    // Asserts reset between edges, clears memories and starts a new scoreboard epoch.
    task automatic start_test();
        @(posedge clk);
        #1 reset = 1'b0;
        armed = 1'b1;
        cur_tid++;
        @(negedge clk);
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        for (int i = 0; i < 16; i++) dmem_init[i] = 8'h00;
        exp_s(0, "reset_out", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic load_prog1();
        imem[0] = 8'h85;  // LDI 5
        imem[1] = 8'h93;  // ADDI 3
        imem[2] = 8'h22;  // STA 2
        imem[3] = 8'h12;  // LDA 2
        dmem_init[2] = 8'h77;
    endtask

    initial begin
        // Store-to-load forwarding.
        start_test();
        load_prog1();
        exp_s(3, "t1_ldi", 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
        exp_s(4, "t1_addi", 8'h04, 8'h08, 1'b0, 1'b0, 1'b0);
        exp_w(4, "t1_sta", 4'h2, 8'h08);
        exp_s(6, "t1_lda_fwd", 8'h06, 8'h08, 1'b0, 1'b0, 1'b0);
        release_rst();
        repeat (8) @(posedge clk);

        // ADD carry, taken JC flushes two LDIs.
        start_test();
        imem[0] = 8'h8F; imem[1] = 8'h30; imem[2] = 8'hE6; imem[3] = 8'h81;
        imem[4] = 8'h82; imem[7] = 8'h89;
        dmem_init[0] = 8'hF5;
        exp_s(3, "t2_ldi", 8'h03, 8'h0F, 1'b0, 1'b0, 1'b0);
        exp_s(4, "t2_add_carry", 8'h04, 8'h04, 1'b0, 1'b1, 1'b0);
        exp_s(5, "t2_jc_target", 8'h06, 8'h04, 1'b0, 1'b1, 1'b0);
        exp_s(6, "t2_flush1", 8'h07, 8'h04, 1'b0, 1'b1, 1'b0);
        exp_s(7, "t2_flush2", 8'h08, 8'h04, 1'b0, 1'b1, 1'b0);
        exp_s(9, "t2_after_branch", 8'h0A, 8'h09, 1'b0, 1'b1, 1'b0);
        release_rst();
        repeat (11) @(posedge clk);

        // SUB to zero, taken JZ, then not-taken JZ without bubble.
        start_test();
        imem[0] = 8'h83; imem[1] = 8'h43; imem[2] = 8'hDA; imem[3] = 8'h87; imem[4] = 8'h87;
        imem[10] = 8'h81; imem[11] = 8'hD0; imem[12] = 8'h86; imem[13] = 8'h92;
        dmem_init[3] = 8'h03;
        exp_s(3, "t3_ldi", 8'h03, 8'h03, 1'b0, 1'b0, 1'b0);
        exp_s(4, "t3_sub_zero", 8'h04, 8'h00, 1'b1, 1'b0, 1'b0);
        exp_s(5, "t3_jz_taken", 8'h0A, 8'h00, 1'b1, 1'b0, 1'b0);
        exp_s(7, "t3_flushed", 8'h0C, 8'h00, 1'b1, 1'b0, 1'b0);
        exp_s(8, "t3_ldi1", 8'h0D, 8'h01, 1'b0, 1'b0, 1'b0);
        exp_s(9, "t3_jz_not_taken", 8'h0E, 8'h01, 1'b0, 1'b0, 1'b0);
        exp_s(10, "t3_no_bubble", 8'h0F, 8'h06, 1'b0, 1'b0, 1'b0);
        exp_s(11, "t3_addi", 8'h10, 8'h08, 1'b0, 1'b0, 1'b0);
        release_rst();
        repeat (13) @(posedge clk);

        // NOT/SHL flags, then HLT freezes everything.
        start_test();
        imem[0] = 8'h8C; imem[1] = 8'hA0; imem[2] = 8'hB0; imem[4] = 8'hF0;
        imem[5] = 8'h81; imem[6] = 8'h82;
        exp_s(3, "t4_ldi", 8'h03, 8'h0C, 1'b0, 1'b0, 1'b0);
        exp_s(4, "t4_not", 8'h04, 8'hF3, 1'b0, 1'b0, 1'b0);
        exp_s(5, "t4_shl", 8'h05, 8'hE6, 1'b0, 1'b1, 1'b0);
        exp_s(6, "t4_pre_halt", 8'h06, 8'hE6, 1'b0, 1'b1, 1'b0);
        exp_s(7, "t4_halted", 8'h06, 8'hE6, 1'b0, 1'b1, 1'b1);
        exp_s(15, "t4_halt_hold", 8'h06, 8'hE6, 1'b0, 1'b1, 1'b1);
        exp_s(27, "t4_halt_20", 8'h06, 8'hE6, 1'b0, 1'b1, 1'b1);
        release_rst();
        repeat (29) @(posedge clk);

        // Program interrupted by asynchronous reset while acc is nonzero.
        start_test();
        load_prog1();
        exp_s(3, "t5_ldi", 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
        exp_s(4, "t5_addi", 8'h04, 8'h08, 1'b0, 1'b0, 1'b0);
        exp_w(4, "t5_sta", 4'h2, 8'h08);
        release_rst();
        repeat (4) @(posedge clk);

        // Restart after reset fetches from 0 again.
        start_test();
        load_prog1();
        exp_s(1, "t6_restart_pc", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        exp_s(3, "t6_ldi", 8'h03, 8'h05, 1'b0, 1'b0, 1'b0);
        exp_w(4, "t6_sta", 4'h2, 8'h08);
        exp_s(6, "t6_lda_fwd", 8'h06, 8'h08, 1'b0, 1'b0, 1'b0);
        release_rst();
        repeat (8) @(posedge clk);

        // All-NOP program: pc wraps modulo 256.
        start_test();
        exp_s(1, "t7_pc1", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        exp_s(255, "t7_pc255", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        exp_s(256, "t7_wrap", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        exp_s(258, "t7_after_wrap", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
        release_rst();
        repeat (260) @(posedge clk);

        start_test();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
